ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit for the execute stage. It computes the 2·WIDTH-bit product or the quotient/remainder of two WIDTH-bit operands, signed or unsigned, and delivers the result into registered HI/LO outputs. It sits beside the single-cycle ALU in `ex`. The stall controller holds the pipeline while `busy_o` is high and writes HI/LO when `done_o` pulses.

## Interface
- WIDTH, 32: operand width; HI/LO are each WIDTH bits; WIDTH ≥ 4.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start_i  input  1  request; accepted only while `busy_o`=0 and `cancel_i`=0.
- op_i  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- src1_i  input  WIDTH  multiplicand / dividend; sampled with start.
- src2_i  input  WIDTH  multiplier / divisor; sampled with start.
- cancel_i  input  1  abort the operation in flight (pipeline flush).
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; `hi_o`/`lo_o` hold the new result in that cycle.
- hi_o  output  WIDTH  MULT: upper product half; DIV: remainder.
- lo_o  output  WIDTH  MULT: lower product half; DIV: quotient.
- div_zero_o  output  1  pulses with `done_o` when a DIV/DIVU had divisor 0.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE → CALC on accepted start. IDLE → FINISH directly on an accepted DIV/DIVU with `src2_i`=0.
- CALC → FINISH after exactly WIDTH iterations; a log2(WIDTH)+1-bit counter tracks them.
- FINISH → IDLE unconditionally.
- Start latching: signed ops latch operand magnitudes (two's-complement negate if MSB=1) and record the result signs.
  - Product sign = sign1 ^ sign2.
  - Quotient sign = sign1 ^ sign2.
  - Remainder sign = sign1.
  - Unsigned ops record both signs as 0.
- Multiply: radix-2 shift-add, one multiplier bit per CALC cycle, into a 2·WIDTH-bit accumulator.
- Divide: restoring shift-subtract, one quotient bit per CALC cycle, with a WIDTH+1-bit partial remainder.
- FINISH: apply the recorded signs (negate the 2·WIDTH product as a whole; negate quotient and remainder separately). Register the results into `hi_o`/`lo_o` and set `done_o`.
- Overflow case DIV 0x80..0 / −1: quotient = 0x80..0, remainder = 0. This falls out of the magnitude path at WIDTH bits and needs no special case.
- Divide by zero: `hi_o` = src1 (unmodified), `lo_o` = all ones, `div_zero_o`=1.
- `hi_o`/`lo_o` change only in the FINISH→IDLE transition. They hold their value across IDLE, CALC, and cancelled operations.
- `start_i` while busy: ignored, no queueing.
- `cancel_i`=1 while `busy_o`=1: next state IDLE. No `done_o`, HI/LO unchanged.
- `cancel_i` and `start_i` both high in the same idle cycle: cancel wins, request not accepted.
- Reset mid-operation: same effect as cancel, plus all outputs cleared.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `div_zero_o`=0, `hi_o`=0, `lo_o`=0, state IDLE, counter 0.
- Normal operation, start accepted in cycle c:
  - `busy_o`=1 in cycles c+1 … c+WIDTH+1 (CALC for WIDTH cycles, then FINISH).
  - `done_o`=1 and new HI/LO in cycle c+WIDTH+2, with `busy_o`=0.
  - Latency is WIDTH+2 (34 at WIDTH=32).
- Divide-by-zero, start in cycle c: `busy_o`=1 in cycle c+1 only; `done_o` and `div_zero_o` high in cycle c+2.
- A new start is accepted in the `done_o` cycle, giving back-to-back issue every WIDTH+2 cycles.
- `done_o` and `div_zero_o` are never high for more than one consecutive cycle from a single start.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Signed multiply: MULT src1=0xFFFFFFFD (−3), src2=7, start in cycle c → `done_o` in cycle c+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy_o` high for exactly 33 cycles.
- Unsigned multiply: MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed/unsigned divide: DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: DIVU 5/0, start in cycle c → `done_o` and `div_zero_o` in cycle c+2; hi=5, lo=0xFFFFFFFF. A following DIVU 9/3 → lo=3, hi=0, `div_zero_o`=0.
- Cancel and ignored start: start MULT 3×4, assert `cancel_i` in cycle c+10 → `busy_o`=0 from c+11, no `done_o`, HI/LO keep the prior result.
  - A second start pulsed during the busy window is ignored.
  - `start_i`+`cancel_i` together while idle → not accepted.
- Reset and back-to-back: `rst` in cycle c+20 of a DIV → all outputs 0 next cycle.
  - Then issue two back-to-back MULTUs (2×3, then 5×6, second started in the `done_o` cycle) → lo=6, then lo=30, with `done_o` pulses 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute-stage stall controller and the
// iterative multiply/divide unit.
//
// Handshake: a request is taken on a rising edge where start_i=1, cancel_i=0
// and busy_o=0. There is no queueing, so a start seen while busy_o=1 is
// dropped. The result is offered for exactly one cycle with done_o=1. hi_o
// and lo_o then hold that result until the next completed operation.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             cancel_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_zero_o;
    logic [1:0]       dbg_state;

    modport master (
        output start_i, op_i, src1_i, src2_i, cancel_i,
        input  busy_o, done_o, hi_o, lo_o, div_zero_o, dbg_state
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, cancel_i,
        output busy_o, done_o, hi_o, lo_o, div_zero_o, dbg_state
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit. It runs a radix-2 shift-add multiply or a
// restoring shift-subtract divide on operand magnitudes, one bit per cycle.
// It applies the result signs in the final cycle and registers HI/LO.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    ex_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               dz;
    logic               sign_p;     // product / quotient sign
    logic               sign_r;     // remainder sign
    logic [WIDTH-1:0]   mag1;       // multiplicand magnitude
    logic [WIDTH-1:0]   mag2;       // divisor magnitude
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half holds dividend bits shifting out / quotient bits in.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;        // partial remainder, always < divisor

    logic               accept;
    logic               sgn_op;
    logic               s1;
    logic               s2;
    logic               zero_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;

    assign accept   = (state == S_IDLE) && bus.start_i && !bus.cancel_i;
    assign sgn_op   = ~bus.op_i[0];
    assign s1       = sgn_op & bus.src1_i[WIDTH-1];
    assign s2       = sgn_op & bus.src2_i[WIDTH-1];
    assign a_mag    = s1 ? -bus.src1_i : bus.src1_i;
    assign b_mag    = s2 ? -bus.src2_i : bus.src2_i;
    assign zero_div = bus.op_i[1] && (bus.src2_i == '0);

    // One multiply step adds the multiplicand when the current multiplier
    // bit is set. One divide step trial-subtracts the divisor from the
    // shifted remainder. A borrow (bit WIDTH set) means the quotient bit is 0.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag1} : '0);
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag2};

    assign prod_fin = sign_p ? -acc : acc;
    assign quo_fin  = sign_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fin  = sign_r ? -rem : rem;

    assign bus.dbg_state = state;

    // Next-state selection; cancel pulls any busy state back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = zero_div ? S_FINISH : S_CALC;
            end
            S_CALC: begin
                if (bus.cancel_i)                  state_nx = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))    state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State, operand latching, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            is_div         <= 1'b0;
            dz             <= 1'b0;
            sign_p         <= 1'b0;
            sign_r         <= 1'b0;
            mag1           <= '0;
            mag2           <= '0;
            acc            <= '0;
            rem            <= '0;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
            bus.div_zero_o <= 1'b0;
            bus.hi_o       <= '0;
            bus.lo_o       <= '0;
        end else begin
            state          <= state_nx;
            bus.busy_o     <= (state_nx != S_IDLE);
            bus.done_o     <= 1'b0;
            bus.div_zero_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_div <= bus.op_i[1];
                        dz     <= zero_div;
                        sign_p <= s1 ^ s2;
                        sign_r <= s1;
                        mag1   <= a_mag;
                        mag2   <= b_mag;
                        cnt    <= '0;
                        rem    <= '0;
                        // Divide-by-zero keeps the raw dividend for HI.
                        if (zero_div)
                            acc <= {{WIDTH{1'b0}}, bus.src1_i};
                        else if (bus.op_i[1])
                            acc <= {{WIDTH{1'b0}}, a_mag};
                        else
                            acc <= {{WIDTH{1'b0}}, b_mag};
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (div_diff[WIDTH]) begin
                            rem            <= div_shift[WIDTH-1:0];
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
                        end else begin
                            rem            <= div_diff[WIDTH-1:0];
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                S_FINISH: begin
                    if (!bus.cancel_i) begin
                        bus.done_o     <= 1'b1;
                        bus.div_zero_o <= dz;
                        if (dz) begin
                            bus.hi_o <= acc[WIDTH-1:0];
                            bus.lo_o <= '1;
                        end else if (is_div) begin
                            bus.hi_o <= rem_fin;
                            bus.lo_o <= quo_fin;
                        end else begin
                            bus.hi_o <= prod_fin[2*WIDTH-1:WIDTH];
                            bus.lo_o <= prod_fin[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv. Results are predicted with plain 64-bit arithmetic
// and pushed into a queue at issue time. A monitor pops one entry per done_o
// pulse and compares result and completion cycle.
module tb_ex_muldiv;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0]  due;
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [W-1:0] hold_hi = '0;
    logic [W-1:0] hold_lo = '0;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        e = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                sp = sa * sb;
                {e.hi, e.lo} = sp;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = up;
            end
            default: begin
                if (b == 0) begin
                    e.dz = 1'b1;
                    e.hi = a;
                    e.lo = '1;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e.lo = sq[W-1:0];
                    e.hi = sr[W-1:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                    chk("hi", 64'(bus.hi_o), 64'(e.hi));
                    chk("lo", 64'(bus.lo_o), 64'(e.lo));
                    chk("div_zero", 64'(bus.div_zero_o), 64'(e.dz));
                    chk("busy_at_done", 64'(bus.busy_o), 64'd0);
                    hold_hi = e.hi;
                    hold_lo = e.lo;
                end
            end else if (bus.div_zero_o) begin
                chk("div_zero_without_done", 64'(bus.div_zero_o), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Caller positions just after a negedge; the next posedge samples start.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        exp_t e;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        if (push) begin
            e = model(op, a, b);
            e.due = cyc + ((op[1] && b == 0) ? 1 : W + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic measure_busy(input string name, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
            n++;
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    task automatic run_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        issue(op, a, b, 1'b1);
        wait_drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen_done;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        bus.start_i  = 1'b0;
        bus.cancel_i = 1'b0;
        bus.op_i     = 2'b00;
        bus.src1_i   = '0;
        bus.src2_i   = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_dz", 64'(bus.div_zero_o), 64'd0);
        chk("rst_hi", 64'(bus.hi_o), 64'd0);
        chk("rst_lo", 64'(bus.lo_o), 64'd0);
        chk("rst_state", 64'(bus.dbg_state), 64'd0);
        rst = 1'b0;

        // Signed multiply with busy window length.
        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        measure_busy("mult_busy_cycles", W + 1);
        wait_drain();

        // Directed corners.
        run_one(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_one(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_one(2'b11, 32'd7, 32'd2);
        run_one(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_one(2'b00, 32'h8000_0000, 32'h8000_0000);

        // Divide by zero, then a normal divide.
        @(negedge clk);
        issue(2'b11, 32'd5, 32'd0, 1'b1);
        measure_busy("dz_busy_cycles", 1);
        wait_drain();
        run_one(2'b11, 32'd9, 32'd3);

        // Cancel mid-operation with an ignored start inside the busy window.
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd4, 1'b0);          // now in cycle c+1
        repeat (3) @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = 2'b11;
        bus.src1_i  = 32'd100;
        bus.src2_i  = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.cancel_i = 1'b1;                      // cycle c+10
        @(posedge clk);
        #1;
        bus.cancel_i = 1'b0;
        @(negedge clk);
        chk("cancel_busy_low", 64'(bus.busy_o), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.done_o) seen_done++;
        end
        chk("cancel_no_done", 64'(seen_done), 64'd0);
        chk("cancel_hold_hi", 64'(bus.hi_o), 64'(hold_hi));
        chk("cancel_hold_lo", 64'(bus.lo_o), 64'(hold_lo));

        // start together with cancel while idle: not accepted.
        bus.cancel_i = 1'b1;
        issue(2'b01, 32'd11, 32'd13, 1'b0);
        bus.cancel_i = 1'b0;
        @(negedge clk);
        chk("start_cancel_busy", 64'(bus.busy_o), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o) seen_done++;
        end
        chk("start_cancel_no_done", 64'(seen_done), 64'd0);

        // Reset in cycle c+20 of a DIV.
        @(negedge clk);
        issue(2'b10, 32'h1234_5678, 32'd77, 1'b0); // cycle c+1
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;                                // cycle c+20
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy_o), 64'd0);
        chk("midrst_done", 64'(bus.done_o), 64'd0);
        chk("midrst_dz", 64'(bus.div_zero_o), 64'd0);
        chk("midrst_hi", 64'(bus.hi_o), 64'd0);
        chk("midrst_lo", 64'(bus.lo_o), 64'd0);
        hold_hi = '0;
        hold_lo = '0;
        #1;
        rst = 1'b0;

        // Back-to-back MULTU, second started in the done cycle.
        @(negedge clk);
        issue(2'b01, 32'd2, 32'd3, 1'b1);
        wait_drain();                               // returns in the done cycle
        issue(2'b01, 32'd5, 32'd6, 1'b1);
        wait_drain();

        // Randomized operations, sometimes issued back-to-back.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 5));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            issue(rop, ra, rb, 1'b1);
            wait_drain();
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
